// File: rtl/sync_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sync_pkg
// Description : Shared helpers for the sync_filter synchroniser/glitch filter.
// Revision    : 1.0 - initial release
// ============================================================================
package sync_pkg;

    // Filter counter width: max(1, clog2(FILT)).
    function automatic int cnt_w(input int filt);
        return (filt <= 2) ? 1 : $clog2(filt);
    endfunction

    function automatic bit params_ok(input int w, input int n, input int filt);
        return (w >= 1) && (n >= 2) && (filt >= 1);
    endfunction

endpackage : sync_pkg
`default_nettype wire

// File: rtl/sync_filter_bit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sync_filter_bit
// Description : One-bit N-flop synchroniser, FILT-cycle glitch filter and
//               registered rise/fall strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_filter_bit
    import sync_pkg::*;
#(
    parameter int   N       = 2,
    parameter int   FILT    = 4,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    localparam int                 c_cnt_w   = cnt_w(FILT);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(FILT - 1);

    (* ASYNC_REG = "TRUE" *) logic [N-1:0] r_sync;

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_q;
    logic               r_rise;
    logic               r_fall;
    logic               w_s;
    logic               w_diff;
    logic               w_expire;

    // Pure flop chain: nothing may sit between stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {N{RST_VAL}};
        end else begin
            r_sync <= {r_sync[N-2:0], d};
        end
    end

    assign w_s      = r_sync[N-1];
    assign w_diff   = w_s ^ r_q;
    assign w_expire = w_diff && (r_cnt == c_cnt_max);

    // Counter clears whenever s agrees with q, so short excursions never add up.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= RST_VAL;
            r_cnt  <= '0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_expire &  w_s;
            r_fall <= w_expire & ~w_s;
            if (!w_diff || w_expire) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_expire) begin
                r_q <= w_s;
            end
        end
    end

    assign q    = r_q;
    assign rise = r_rise;
    assign fall = r_fall;

endmodule : sync_filter_bit
`default_nettype wire

// File: rtl/sync_filter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sync_filter
// Description : W independent synchronised, glitch-filtered level inputs with
//               registered edge strobes and a combined change flag.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_filter
    import sync_pkg::*;
#(
    parameter int           W       = 1,
    parameter int           N       = 2,
    parameter int           FILT    = 4,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall,
    output logic         chg
);

    generate
        if (!params_ok(W, N, FILT)) begin : g_param_err
            $error("sync_filter: requires W >= 1, N >= 2, FILT >= 1");
        end
    endgenerate

    generate
        for (genvar i = 0; i < W; i++) begin : g_bit
            sync_filter_bit #(
                .N       (N),
                .FILT    (FILT),
                .RST_VAL (RST_VAL[i])
            ) u_bit (
                .clk  (clk),
                .rst  (rst),
                .d    (d[i]),
                .q    (q[i]),
                .rise (rise[i]),
                .fall (fall[i])
            );
        end
    endgenerate

    // Built only from registered strobes, so it carries the same timing.
    assign chg = |(rise | fall);

endmodule : sync_filter
`default_nettype wire
